wb_dma_mem_arbiter: RTL and testbench

//  Shares the single wishbone memory master port between two DMA masters (e.g. ppfifo->mem

---
 rtl/wb_dma_mem_arbiter_if.sv | 27 ++
 rtl/wb_dma_mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_wb_dma_mem_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_dma_mem_arbiter_if.sv
// Wishbone master-to-slave link used on each side of the DMA memory arbiter.
// The master modport drives the request side; the slave modport returns data, ack and interrupt.
interface wb_dma_mem_arbiter_if;
  localparam int unsigned SEL_W = 4;
  localparam int unsigned ADR_W = 32;
  localparam int unsigned DAT_W = 32;

  logic             we;
  logic             stb;
  logic             cyc;
  logic [SEL_W-1:0] sel;
  logic [ADR_W-1:0] adr;
  logic [DAT_W-1:0] dat_w;
  logic [DAT_W-1:0] dat_r;
  logic             ack;
  logic             irq;

  modport master (
    output we, stb, cyc, sel, adr, dat_w,
    input  dat_r, ack, irq
  );

  modport slave (
    input  we, stb, cyc, sel, adr, dat_w,
    output dat_r, ack, irq
  );
endinterface

// File: rtl/wb_dma_mem_arbiter.sv
// Shares one wishbone memory master port between two DMA masters: round-robin on
// contention, grant held for the whole cyc, watchdog revokes a grant stalled without ack.
module wb_dma_mem_arbiter #(
  parameter int unsigned TIMEOUT   = 1024,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  wb_dma_mem_arbiter_if.slave         io_m0,
  wb_dma_mem_arbiter_if.slave         io_m1,
  wb_dma_mem_arbiter_if.master        io_mem,
  output logic [1:0]                  o_grant,
  output logic                        o_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } state_t;

  localparam bit                   WDOG_EN  = (TIMEOUT > 0);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_WIDTH'(TIMEOUT - 1) : '0;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  state_t               r_state;
  state_t               w_next;
  logic [1:0]           r_grant;
  logic                 r_timeout;
  logic                 r_last;     // 1: m1 held the bus most recently
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_block0;
  logic                 r_block1;

  logic                 w_req0;
  logic                 w_req1;
  logic                 w_own_cyc;
  logic                 w_expire;

  // A master that was timed out stays out of arbitration until it drops cyc
  assign w_req0 = io_m0.cyc & ~r_block0;
  assign w_req1 = io_m1.cyc & ~r_block1;

  always_comb begin
    w_own_cyc = 1'b0;
    case (r_state)
      ST_GRANT0: w_own_cyc = io_m0.cyc;
      ST_GRANT1: w_own_cyc = io_m1.cyc;
      default:   w_own_cyc = 1'b0;
    endcase
  end

  // Ack on the threshold cycle wins over the watchdog
  assign w_expire = WDOG_EN && (r_state != ST_IDLE) && w_own_cyc &&
                    !io_mem.ack && (r_cnt == CNT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_grant   <= 2'b00;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_grant   <= {w_next == ST_GRANT1, w_next == ST_GRANT0};
      r_timeout <= w_expire;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_req0 && w_req1)
          w_next = r_last ? ST_GRANT0 : ST_GRANT1;
        else if (w_req0)
          w_next = ST_GRANT0;
        else if (w_req1)
          w_next = ST_GRANT1;
      end
      ST_GRANT0: begin
        if (!io_m0.cyc || w_expire)
          w_next = w_req1 ? ST_GRANT1 : ST_IDLE;
      end
      ST_GRANT1: begin
        if (!io_m1.cyc || w_expire)
          w_next = w_req0 ? ST_GRANT0 : ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Round-robin history, watchdog counter and block flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last   <= 1'b1;
      r_cnt    <= '0;
      r_block0 <= 1'b0;
      r_block1 <= 1'b0;
    end else begin
      if (r_state == ST_GRANT0 && w_next != ST_GRANT0)
        r_last <= 1'b0;
      else if (r_state == ST_GRANT1 && w_next != ST_GRANT1)
        r_last <= 1'b1;

      if (w_next != r_state || r_state == ST_IDLE || io_mem.ack)
        r_cnt <= '0;
      else if (r_cnt != CNT_MAX)
        r_cnt <= r_cnt + CNT_WIDTH'(1);

      if (w_expire && r_state == ST_GRANT0)
        r_block0 <= 1'b1;
      else if (!io_m0.cyc)
        r_block0 <= 1'b0;

      if (w_expire && r_state == ST_GRANT1)
        r_block1 <= 1'b1;
      else if (!io_m1.cyc)
        r_block1 <= 1'b0;
    end
  end

  // Output routing: mux on the registered grant; non-granted side sees zeros
  always_comb begin
    io_mem.we    = 1'b0;
    io_mem.stb   = 1'b0;
    io_mem.cyc   = 1'b0;
    io_mem.sel   = '0;
    io_mem.adr   = '0;
    io_mem.dat_w = '0;
    io_m0.ack    = 1'b0;
    io_m0.dat_r  = '0;
    io_m1.ack    = 1'b0;
    io_m1.dat_r  = '0;
    io_m0.irq    = io_mem.irq;
    io_m1.irq    = io_mem.irq;
    case (r_state)
      ST_GRANT0: begin
        io_mem.we    = io_m0.we;
        io_mem.stb   = io_m0.stb;
        io_mem.cyc   = io_m0.cyc;
        io_mem.sel   = io_m0.sel;
        io_mem.adr   = io_m0.adr;
        io_mem.dat_w = io_m0.dat_w;
        io_m0.ack    = io_mem.ack;
        io_m0.dat_r  = io_mem.dat_r;
      end
      ST_GRANT1: begin
        io_mem.we    = io_m1.we;
        io_mem.stb   = io_m1.stb;
        io_mem.cyc   = io_m1.cyc;
        io_mem.sel   = io_m1.sel;
        io_mem.adr   = io_m1.adr;
        io_mem.dat_w = io_m1.dat_w;
        io_m1.ack    = io_mem.ack;
        io_m1.dat_r  = io_mem.dat_r;
      end
      default: ;
    endcase
  end

  assign o_grant   = r_grant;
  assign o_timeout = r_timeout;

endmodule

// File: tb/tb_wb_dma_mem_arbiter.sv
// Self-checking bench for wb_dma_mem_arbiter: directed table, hand-written corner
// sequences, then randomized traffic against an owner/queue-style reference model.
module tb_wb_dma_mem_arbiter;
  localparam int unsigned TO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] grant;
  logic       tmo;

  always #5 clk = ~clk;

  wb_dma_mem_arbiter_if m0_if ();
  wb_dma_mem_arbiter_if m1_if ();
  wb_dma_mem_arbiter_if mem_if ();

  wb_dma_mem_arbiter #(.TIMEOUT(TO), .CNT_WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .io_m0     (m0_if),
    .io_m1     (m1_if),
    .io_mem    (mem_if),
    .o_grant   (grant),
    .o_timeout (tmo)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit c0, input bit c1, input bit ack);
    rst        = r;
    m0_if.cyc  = c0;
    m0_if.stb  = c0;
    m1_if.cyc  = c1;
    m1_if.stb  = c1;
    mem_if.ack = ack;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Directed vectors: inputs driven for one cycle, outputs expected in that cycle
  typedef struct {
    bit       rst, c0, c1, ack;
    bit [1:0] grant;
    bit       ack0, ack1, mcyc;
  } vec_t;

  vec_t vt[14];

  // Reference model: who owns the bus, who had it last, stall length, lockouts
  int m_owner;
  int m_last;
  int m_stall;
  bit m_blk[2];
  bit m_tp;

  task automatic model_step(input bit r, input bit c0, input bit c1, input bit ack);
    bit cyc[2];
    bit elig[2];
    int nw;
    int other;
    int timed_out;
    bit done;
    bit starved;
    if (r) begin
      m_owner = -1; m_last = 1; m_stall = 0; m_blk[0] = 0; m_blk[1] = 0; m_tp = 0;
      return;
    end
    cyc[0] = c0; cyc[1] = c1;
    for (int n = 0; n < 2; n++) elig[n] = cyc[n] && !m_blk[n];
    m_tp = 0; nw = m_owner; timed_out = -1;
    if (m_owner < 0) begin
      if (elig[0] && elig[1]) nw = 1 - m_last;
      else if (elig[0])       nw = 0;
      else if (elig[1])       nw = 1;
    end else begin
      other   = 1 - m_owner;
      done    = !cyc[m_owner];
      starved = cyc[m_owner] && !ack && (m_stall == int'(TO) - 1);
      if (done || starved) begin
        nw = elig[other] ? other : -1;
        m_last = m_owner;
        if (starved) begin m_tp = 1; timed_out = m_owner; end
      end
    end
    for (int n = 0; n < 2; n++) begin
      if (n == timed_out) m_blk[n] = 1;
      else if (!cyc[n])   m_blk[n] = 0;
    end
    if (nw != m_owner || m_owner < 0 || ack) m_stall = 0;
    else m_stall++;
    m_owner = nw;
  endtask

  function automatic logic [70:0] req0();
    return {m0_if.we, m0_if.stb, m0_if.cyc, m0_if.sel, m0_if.adr, m0_if.dat_w};
  endfunction
  function automatic logic [70:0] req1();
    return {m1_if.we, m1_if.stb, m1_if.cyc, m1_if.sel, m1_if.adr, m1_if.dat_w};
  endfunction

  task automatic check_model();
    logic [70:0] exp_mem;
    exp_mem = (m_owner == 0) ? req0() : (m_owner == 1) ? req1() : '0;
    chk("rnd_grant", grant, (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00);
    chk("rnd_timeout", tmo, m_tp);
    chk("rnd_mem_bus", {mem_if.we, mem_if.stb, mem_if.cyc, mem_if.sel, mem_if.adr, mem_if.dat_w}, exp_mem);
    chk("rnd_ack0", m0_if.ack, (m_owner == 0) && mem_if.ack);
    chk("rnd_ack1", m1_if.ack, (m_owner == 1) && mem_if.ack);
    chk("rnd_dat0", m0_if.dat_r, (m_owner == 0) ? mem_if.dat_r : 32'h0);
    chk("rnd_dat1", m1_if.dat_r, (m_owner == 1) ? mem_if.dat_r : 32'h0);
    chk("rnd_int", {m0_if.irq, m1_if.irq}, {mem_if.irq, mem_if.irq});
  endtask

  initial begin
    int granted;
    int pct;
    rst = 1'b1;
    m0_if.we = 0; m0_if.stb = 0; m0_if.cyc = 0; m0_if.sel = '0; m0_if.adr = '0; m0_if.dat_w = '0;
    m1_if.we = 0; m1_if.stb = 0; m1_if.cyc = 0; m1_if.sel = '0; m1_if.adr = '0; m1_if.dat_w = '0;
    mem_if.dat_r = '0; mem_if.ack = 0; mem_if.irq = 0;

    //               rst c0 c1 ack grant ack0 ack1 mcyc
    vt[0]  = '{0, 1, 1, 0, 2'b00, 0, 0, 0};
    vt[1]  = '{0, 1, 1, 1, 2'b01, 1, 0, 1};
    vt[2]  = '{0, 0, 1, 1, 2'b01, 1, 0, 0};
    vt[3]  = '{0, 1, 1, 0, 2'b10, 0, 0, 1};
    vt[4]  = '{0, 1, 0, 1, 2'b10, 0, 1, 0};
    vt[5]  = '{0, 0, 0, 0, 2'b01, 0, 0, 0};
    vt[6]  = '{0, 0, 0, 1, 2'b00, 0, 0, 0};
    vt[7]  = '{0, 1, 1, 0, 2'b00, 0, 0, 0};
    vt[8]  = '{0, 0, 0, 0, 2'b10, 0, 0, 0};
    vt[9]  = '{0, 1, 1, 0, 2'b00, 0, 0, 0};
    vt[10] = '{0, 1, 1, 1, 2'b01, 1, 0, 1};
    vt[11] = '{1, 1, 1, 1, 2'b01, 1, 0, 1};
    vt[12] = '{0, 1, 1, 1, 2'b00, 0, 0, 0};
    vt[13] = '{0, 0, 0, 0, 2'b01, 0, 0, 0};

    // Reset state and single-master grant
    do_reset();
    #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_timeout", tmo, 1'b0);
    chk("rst_mem_cyc", mem_if.cyc, 1'b0);
    chk("rst_ack0", m0_if.ack, 1'b0);
    chk("rst_dat0", m0_if.dat_r, 32'h0);
    @(negedge clk);
    m0_if.cyc = 1; m0_if.stb = 1; m0_if.adr = 32'h100; mem_if.dat_r = 32'hDEADBEEF;
    #1 chk("t1_grant_latency", grant, 2'b00);
    @(negedge clk);
    mem_if.ack = 1;
    #1;
    chk("t1_grant", grant, 2'b01);
    chk("t1_mem_adr", mem_if.adr, 32'h100);
    chk("t1_ack0", m0_if.ack, 1'b1);
    chk("t1_dat0", m0_if.dat_r, 32'hDEADBEEF);
    chk("t1_ack1", m1_if.ack, 1'b0);

    // Tie alternation, back-to-back handover, dropped idle ack, mid-transfer reset
    do_reset();
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(vt[i].rst, vt[i].c0, vt[i].c1, vt[i].ack);
      #1;
      chk($sformatf("vec%0d_grant", i), grant, vt[i].grant);
      chk($sformatf("vec%0d_ack0", i), m0_if.ack, vt[i].ack0);
      chk($sformatf("vec%0d_ack1", i), m1_if.ack, vt[i].ack1);
      chk($sformatf("vec%0d_mcyc", i), mem_if.cyc, vt[i].mcyc);
      chk($sformatf("vec%0d_tmo", i), tmo, 1'b0);
    end

    // m1 burst of 8 acks with m0 waiting; interrupt broadcast; idle ack dropped
    do_reset();
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    #1 chk("t3_grant_m1", grant, 2'b10);
    m0_if.cyc = 1; m0_if.stb = 1; mem_if.ack = 1; mem_if.irq = 1;
    #1;
    chk("t5_int0", m0_if.irq, 1'b1);
    chk("t5_int1", m1_if.irq, 1'b1);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      chk("t3_burst_grant", grant, 2'b10);
      chk("t3_burst_ack1", m1_if.ack, 1'b1);
      chk("t3_burst_ack0", m0_if.ack, 1'b0);
    end
    m1_if.cyc = 0; m1_if.stb = 0; mem_if.irq = 0;
    @(negedge clk);
    #1;
    chk("t3_handover", grant, 2'b01);
    chk("t3_ack0_after", m0_if.ack, 1'b1);
    chk("t3_ack1_after", m1_if.ack, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    chk("t5_idle_grant", grant, 2'b00);
    chk("t5_idle_ack0", m0_if.ack, 1'b0);
    chk("t5_idle_ack1", m1_if.ack, 1'b0);

    // Watchdog: m0 stalls, grant revoked after TO granted cycles, lockout until cyc drops
    do_reset();
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    granted = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (grant == 2'b01) granted++;
      else if (granted > 0) break;
    end
    chk("t4_granted_cycles", granted, TO);
    chk("t4_grant_revoked", grant, 2'b00);
    chk("t4_timeout_pulse", tmo, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("t4_blocked_grant", grant, 2'b00);
      chk("t4_pulse_ended", tmo, 1'b0);
    end
    m0_if.cyc = 0; m0_if.stb = 0;
    @(negedge clk);
    m0_if.cyc = 1; m0_if.stb = 1;
    #1 chk("t4_still_idle", grant, 2'b00);
    @(negedge clk);
    #1 chk("t4_regrant", grant, 2'b01);

    // Randomized traffic against the reference model
    pct = 50;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (i % 100 == 0) begin
        case ($urandom_range(0, 2))
          0:       pct = 0;
          1:       pct = 10;
          default: pct = 60;
        endcase
      end
      rst = (i == 0) || ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 9) == 0) m0_if.cyc = ~m0_if.cyc;
      if ($urandom_range(0, 9) == 0) m1_if.cyc = ~m1_if.cyc;
      m0_if.stb = m0_if.cyc & 1'($urandom);
      m1_if.stb = m1_if.cyc & 1'($urandom);
      m0_if.we = 1'($urandom); m0_if.sel = 4'($urandom); m0_if.adr = $urandom; m0_if.dat_w = $urandom;
      m1_if.we = 1'($urandom); m1_if.sel = 4'($urandom); m1_if.adr = $urandom; m1_if.dat_w = $urandom;
      mem_if.ack   = ($urandom_range(0, 99) < pct);
      mem_if.irq   = ($urandom_range(0, 7) == 0);
      mem_if.dat_r = $urandom;
      #1;
      if (i > 0) check_model();
      @(posedge clk);
      model_step(rst, m0_if.cyc, m1_if.cyc, mem_if.ack);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL sim_time_limit: got no end expected end before limit");
    $fatal(1, "time limit");
  end

endmodule
